// File: rtl/dll_ctrl_pkg.sv
// dll_ctrl_pkg: shared state, direction and code definitions for the DLL tap controller
package dll_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SAR = 2'd1, TRACK = 2'd2, LOCKED = 2'd3} state_t;
  typedef enum logic [1:0] {HOLD = 2'd0, UP = 2'd1, DN = 2'd2} dir_t;
  localparam int CODE_W = 4;
  localparam logic [CODE_W-1:0] CODE_MIN = 4'd1;
  localparam logic [CODE_W-1:0] CODE_MAX = 4'd15;
  function automatic dir_t decide(input logic up, input logic dn);
    return (up & ~dn) ? UP : (dn & ~up) ? DN : HOLD;
  endfunction
endpackage

// File: rtl/dll_settle_timer.sv
// dll_settle_timer: free-running decision window counter, done on the last clock of each window
module dll_settle_timer #(
  parameter int SETTLE_CYC = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic done
);
  localparam int W = $clog2(SETTLE_CYC);
  logic [W-1:0] cnt;
  assign done = cnt == W'(SETTLE_CYC - 1);
  always_ff @(posedge clk) begin
    if (rst || clr || done) cnt <= '0;
    else cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/dll_tap_ctrl.sv
// dll_tap_ctrl: SAR acquisition then +/-1 tracking of the delay-line tap code with lock detection
module dll_tap_ctrl
  import dll_ctrl_pkg::*;
#(
  parameter int SETTLE_CYC = 8,
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              pd_up,
  input  logic              pd_dn,
  output logic [CODE_W-1:0] q,
  output logic              locked,
  output logic              busy,
  output logic              sat
);
  state_t            state;
  dir_t              prev;
  dir_t              d;
  logic [1:0]        bit_idx;
  logic [7:0]        stable_cnt, drift_cnt, stable_n, drift_n;
  logic              done, same, sat_n;
  logic [CODE_W-1:0] q_trk, sar_k, sar_n;
  dll_settle_timer #(.SETTLE_CYC(SETTLE_CYC)) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (state == IDLE || !en),
    .done(done)
  );
  assign busy = state != IDLE;
  always_comb begin
    d        = decide(pd_up, pd_dn);
    same     = d != HOLD && d == prev;
    sat_n    = (d == UP && q == CODE_MAX) || (d == DN && q == CODE_MIN);
    q_trk    = sat_n ? q : d == UP ? q + 4'd1 : d == DN ? q - 4'd1 : q;
    stable_n = same ? 8'd1 : stable_cnt + 8'd1;
    drift_n  = d == HOLD ? 8'd0 : same ? drift_cnt + 8'd1 : 8'd1;
    sar_k    = d == DN ? q & ~(4'b0001 << bit_idx) : q;
    sar_n    = bit_idx != 2'd0 ? sar_k | (4'b0001 << (bit_idx - 2'd1)) :
               sar_k == 4'd0 ? CODE_MIN : sar_k;
  end
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state      <= IDLE;
      q          <= '0;
      locked     <= 1'b0;
      sat        <= 1'b0;
      bit_idx    <= 2'd0;
      prev       <= HOLD;
      stable_cnt <= '0;
      drift_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          q       <= 4'b1000;
          bit_idx <= 2'd3;
          state   <= SAR;
        end
        SAR: if (done) begin
          q       <= sar_n;
          bit_idx <= bit_idx - 2'd1;
          if (bit_idx == 2'd0) begin
            state      <= TRACK;
            prev       <= HOLD;
            stable_cnt <= '0;
          end
        end
        TRACK: if (done) begin
          q          <= q_trk;
          sat        <= sat_n;
          prev       <= d == HOLD ? prev : d;
          stable_cnt <= stable_n;
          if (stable_n == 8'(LOCK_CNT)) begin
            locked    <= 1'b1;
            drift_cnt <= '0;
            state     <= LOCKED;
          end
        end
        LOCKED: if (done) begin
          q         <= q_trk;
          sat       <= sat_n;
          prev      <= d == HOLD ? prev : d;
          drift_cnt <= drift_n;
          if (drift_n == 8'(UNLOCK_CNT)) begin
            locked     <= 1'b0;
            stable_cnt <= '0;
            state      <= TRACK;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dll_tap_ctrl.sv
// tb_dll_tap_ctrl: scoreboarded random and directed checks of dll_tap_ctrl against a window-level model
module tb_dll_tap_ctrl;
  localparam int S = 8;
  logic clk = 0, rst = 1, en = 0, pd_up = 0, pd_dn = 0;
  logic [3:0] q;
  logic locked, busy, sat;
  int cyc = 0, tests = 0, fails = 0;
  typedef struct {int cyc; int q; bit l; bit b; bit s;} exp_t;
  exp_t exp_q[$];
  int m_ph = 0, m_t = 0, m_q = 0, m_bit = 0, m_last = 0, m_stab = 0, m_drift = 0;
  bit m_lock = 0, m_sat = 0;

  dll_tap_ctrl #(.SETTLE_CYC(S), .LOCK_CNT(4), .UNLOCK_CNT(3)) dut (
    .clk(clk), .rst(rst), .en(en), .pd_up(pd_up), .pd_dn(pd_dn),
    .q(q), .locked(locked), .busy(busy), .sat(sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      tests++;
      if (q !== 4'(e.q) || locked !== e.l || busy !== e.b || sat !== e.s) begin
        fails++;
        $display("FAIL scoreboard cyc=%0d got q=%0d locked=%0b busy=%0b sat=%0b want q=%0d locked=%0b busy=%0b sat=%0b",
                 cyc, q, locked, busy, sat, e.q, e.l, e.b, e.s);
      end
    end
  end

  // phases: 0 idle, 1 SAR, 2 track, 3 locked; decisions +1 / -1 / 0
  task automatic model(input bit r, input bit e, input bit u, input bit d);
    int dec, nq;
    bit same;
    if (r || !e) begin
      m_ph = 0; m_t = 0; m_q = 0; m_bit = 0; m_last = 0; m_stab = 0; m_drift = 0; m_lock = 0; m_sat = 0;
    end else if (m_ph == 0) begin
      m_ph = 1; m_t = 0; m_q = 8; m_bit = 3;
    end else if (m_t != S - 1) begin
      m_t++;
    end else begin
      m_t = 0;
      dec = (u && !d) ? 1 : (d && !u) ? -1 : 0;
      if (m_ph == 1) begin
        if (dec < 0) m_q -= (1 << m_bit);
        if (m_bit > 0) begin
          m_bit--;
          m_q += (1 << m_bit);
        end else begin
          m_ph = 2; m_last = 0; m_stab = 0;
          if (m_q == 0) m_q = 1;
        end
      end else begin
        nq = m_q + dec;
        m_sat = nq < 1 || nq > 15;
        if (!m_sat) m_q = nq;
        same = dec != 0 && dec == m_last;
        if (dec != 0) m_last = dec;
        if (m_ph == 2) begin
          m_stab = same ? 1 : m_stab + 1;
          if (m_stab == 4) begin m_ph = 3; m_lock = 1; m_drift = 0; end
        end else begin
          m_drift = dec == 0 ? 0 : same ? m_drift + 1 : 1;
          if (m_drift == 3) begin m_ph = 2; m_lock = 0; m_stab = 0; end
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit e, input bit u, input bit d);
    exp_t x;
    rst = r; en = e; pd_up = u; pd_dn = d;
    model(r, e, u, d);
    x.cyc = cyc + 1; x.q = m_q; x.l = m_lock; x.b = m_ph != 0; x.s = m_sat;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // pd modes: 0 target tracking, 1 dn stuck, 2 both high, 3 random
  task automatic run(input int n, input int mode, input int tgt);
    for (int i = 0; i < n; i++) begin
      bit u, d;
      u = mode == 0 ? m_q < tgt : mode == 2 ? 1'b1 : mode == 3 ? 1'($urandom) : 1'b0;
      d = mode == 0 ? m_q > tgt : mode == 3 ? 1'($urandom) : 1'b1;
      step(0, 1, u, d);
    end
  endtask

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s got %0d want %0d", name, act, req);
    end
  endtask

  initial begin
    #1;
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    check("reset_q", q, 0);
    check("reset_busy", busy, 0);
    check("reset_locked", locked, 0);
    run(1, 0, 11);
    check("sar_start_q", q, 8);
    run(32, 0, 11);
    check("acq_q11", q, 11);
    check("acq_not_locked", locked, 0);
    run(32, 0, 11);
    check("lock_at_11", locked, 1);
    run(24, 0, 14);
    check("drift_to_14", q, 14);
    check("unlock_after_drift", locked, 0);
    run(32, 0, 14);
    check("relock_14", locked, 1);
    step(0, 0, 0, 0);
    check("drop_locked_q", q, 0);
    check("drop_locked_flag", locked, 0);
    run(80, 1, 0);
    check("dn_stuck_q", q, 1);
    check("dn_stuck_sat", sat, 1);
    check("dn_stuck_unlocked", locked, 0);
    step(0, 0, 0, 0);
    run(12, 0, 11);
    check("mid_sar_q", q, 12);
    step(0, 0, 0, 0);
    check("mid_sar_drop_q", q, 0);
    check("mid_sar_drop_busy", busy, 0);
    run(1, 0, 11);
    check("restart_q", q, 8);
    step(0, 0, 0, 0);
    run(65, 2, 0);
    check("both_q15", q, 15);
    check("both_locked", locked, 1);
    for (int k = 0; k < 30; k++) begin
      int sel;
      run($urandom_range(10, 160), $urandom_range(0, 3), $urandom_range(1, 15));
      sel = $urandom_range(0, 2);
      if (sel == 0) repeat ($urandom_range(1, 3)) step(0, 0, 1'($urandom), 1'($urandom));
      else if (sel == 1) step(1, 1'($urandom), 1'($urandom), 1'($urandom));
    end
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
